// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button control stage (btn_ctrl).
// Per-channel debounce FSM state encoding and the default debounce period.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_t;

    // 20 ms at 100 MHz
    localparam int DB_TICKS_DEFAULT = 2_000_000;

endpackage

// File: rtl/btn_ctrl_if.sv
// Button/level bundle between the raw buttons and btn_ctrl; also carries the
// two debounce FSM states so checkers can observe them.
interface btn_ctrl_if;
    import btn_pkg::*;

    // Level signals only: there is no handshake on this bundle. Buttons are
    // raw levels, ticks are single-cycle strobes with no back-pressure.
    logic      btn_dir;
    logic      btn_pause;
    logic      cw;
    logic      enable;
    logic      dir_tick;
    logic      pause_tick;
    db_state_t dir_state;
    db_state_t pause_state;

    modport master (
        output btn_dir, btn_pause,
        input  cw, enable, dir_tick, pause_tick, dir_state, pause_state
    );

    modport slave (
        input  btn_dir, btn_pause,
        output cw, enable, dir_tick, pause_tick, dir_state, pause_state
    );

endinterface

// File: rtl/btn_debounce.sv
// One debounce channel: optional 2-flop synchroniser (BTN_SYNC_EN), press/release
// FSM with hold counter, registered 1-cycle tick on each accepted press.
module btn_debounce
    import btn_pkg::*;
#(
    parameter  int DB_TICKS  = DB_TICKS_DEFAULT,
    localparam int CNT_WIDTH = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      btn,
    output logic      tick,
    output logic      press,
    output db_state_t state
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DB_TICKS - 1);

    logic                 x;
    db_state_t            state_q;
    db_state_t            state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

`ifdef BTN_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    assign x = sync_q[1];
`else
    assign x = btn;
`endif

    // press is the D input of tick, so the toggle flops in the parent can
    // flip on the same edge that tick rises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        case (state_q)
            IDLE: begin
                if (x) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!x) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!x) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (x) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick    <= press;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/btn_ctrl.sv
// Button control stage: two debounced channels, each accepted press gives a tick
// and toggles cw / enable. Optional input synchronisers via BTN_SYNC_EN.
module btn_ctrl
    import btn_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input logic       clk,
    input logic       reset,
    btn_ctrl_if.slave bus
);

    logic dir_press;
    logic pause_press;
    logic cw_q;
    logic enable_q;

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_dir (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_dir),
        .tick  (bus.dir_tick),
        .press (dir_press),
        .state (bus.dir_state)
    );

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_pause (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_pause),
        .tick  (bus.pause_tick),
        .press (pause_press),
        .state (bus.pause_state)
    );

    // Power up rotating clockwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cw_q     <= 1'b1;
            enable_q <= 1'b1;
        end else begin
            if (dir_press)   cw_q     <= ~cw_q;
            if (pause_press) enable_q <= ~enable_q;
        end
    end

    assign bus.cw     = cw_q;
    assign bus.enable = enable_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl with DB_TICKS=4: vector table, directed corner sequences,
// and randomized bouncy buttons against a run-length reference model.
module tb_btn_ctrl;
  import btn_pkg::*;

  localparam int DB = 4;
`ifdef BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = DB + 1 + SYNC_LAT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  btn_ctrl_if bus();

  btn_ctrl #(.DB_TICKS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int dt_cnt = 0;
  int pt_cnt = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       dir;
    logic       pause;
    logic [3:0] exp;  // {cw, enable, dir_tick, pause_tick}
  } vec_t;
  vec_t vt[$];

  function automatic logic [3:0] outs();
    return {bus.cw, bus.enable, bus.dir_tick, bus.pause_tick};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    bus.btn_dir = 1'b0;
    bus.btn_pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dt_cnt = 0;
    pt_cnt = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (bus.dir_tick) dt_cnt++;
    if (bus.pause_tick) pt_cnt++;
  endtask

  // ---------------- reference model ----------------
  // A channel's debounced level flips once the raw input has differed from it
  // for DB+1 consecutive samples; a 0->1 flip is a press.
  int   m_run[2];
  logic m_lvl[2];
  logic m_d1[2];
  logic m_d2[2];
  logic m_cw;
  logic m_en;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_run[c] = 0;
      m_lvl[c] = 1'b0;
      m_d1[c] = 1'b0;
      m_d2[c] = 1'b0;
    end
    m_cw = 1'b1;
    m_en = 1'b1;
  endtask

  task automatic model_chan(input int c, input logic raw, output logic tk);
    logic x;
`ifdef BTN_SYNC_EN
    x = m_d2[c];
    m_d2[c] = m_d1[c];
    m_d1[c] = raw;
`else
    x = raw;
`endif
    tk = 1'b0;
    if (x != m_lvl[c]) m_run[c]++;
    else m_run[c] = 0;
    if (m_run[c] == DB + 1) begin
      m_lvl[c] = x;
      m_run[c] = 0;
      tk = x;
    end
  endtask

  task automatic model_step(input logic rd, input logic rp, output logic [3:0] e);
    logic td, tp;
    model_chan(0, rd, td);
    model_chan(1, rp, tp);
    if (td) m_cw = ~m_cw;
    if (tp) m_en = ~m_en;
    e = {m_cw, m_en, td, tp};
  endtask

  // ---------------- test ----------------
  initial begin
    int first_d;
    int first_p;
    int hold[2];
    logic val[2];
    logic [3:0] e;
    int nv;

    // vector table: dir press held 20, release 6, pause bounce 1,0,1,1,0 then 0
    for (int i = 0; i < 20; i++)
      vt.push_back('{1'b1, 1'b0, (i < 4) ? 4'b1100 : ((i == 4) ? 4'b0110 : 4'b0100)});
    for (int i = 0; i < 6; i++) vt.push_back('{1'b0, 1'b0, 4'b0100});
    vt.push_back('{1'b0, 1'b1, 4'b0100});
    vt.push_back('{1'b0, 1'b0, 4'b0100});
    vt.push_back('{1'b0, 1'b1, 4'b0100});
    vt.push_back('{1'b0, 1'b1, 4'b0100});
    for (int i = 0; i < 6; i++) vt.push_back('{1'b0, 1'b0, 4'b0100});

    bus.btn_dir = 1'b0;
    bus.btn_pause = 1'b0;

    // case 1: reset values, no press
    do_reset();
    check("rst_dir_state", 32'(bus.dir_state), 32'(IDLE));
    check("rst_pause_state", 32'(bus.pause_state), 32'(IDLE));
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("idle_outs", 32'(outs()), 32'h c);
    end

    // cases 2/3: table; with synchronisers outputs lag by SYNC_LAT
    nv = vt.size();
    for (int i = 0; i < nv + SYNC_LAT; i++) begin
      int k;
      k = (i < nv) ? i : nv - 1;
      bus.btn_dir = vt[k].dir;
      bus.btn_pause = vt[k].pause;
      cycle();
      if (i >= SYNC_LAT) check($sformatf("vec%0d", i - SYNC_LAT), 32'(outs()), 32'(vt[i - SYNC_LAT].exp));
    end
    check("vec_dir_ticks", 32'(dt_cnt), 32'd1);
    check("vec_pause_ticks", 32'(pt_cnt), 32'd0);

    // case 4: both buttons rise together
    do_reset();
    bus.btn_dir = 1'b1;
    bus.btn_pause = 1'b1;
    first_d = 0;
    first_p = 0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (bus.dir_tick && first_d == 0) first_d = c;
      if (bus.pause_tick && first_p == 0) first_p = c;
    end
    check("both_dir_lat", 32'(first_d), 32'(LAT));
    check("both_pause_lat", 32'(first_p), 32'(LAT));
    check("both_counts", 32'({dt_cnt[7:0], pt_cnt[7:0]}), 32'h0101);
    check("both_levels", 32'({bus.cw, bus.enable}), 32'd0);

    // case 5: short release is a bounce, full release re-arms
    do_reset();
    bus.btn_dir = 1'b1;
    repeat (LAT + 2) cycle();
    bus.btn_dir = 1'b0;
    repeat (2) cycle();
    bus.btn_dir = 1'b1;
    repeat (10) cycle();
    check("rearm_one_tick", 32'(dt_cnt), 32'd1);
    check("rearm_cw0", 32'(bus.cw), 32'd0);
    bus.btn_dir = 1'b0;
    repeat (LAT + 1) cycle();
    bus.btn_dir = 1'b1;
    repeat (LAT + 3) cycle();
    check("rearm_two_ticks", 32'(dt_cnt), 32'd2);
    check("rearm_cw1", 32'(bus.cw), 32'd1);

    // case 6: reset mid WAIT_PRESS with button held
    do_reset();
    bus.btn_dir = 1'b1;
    repeat (LAT - 3) cycle();
    check("mid_state", 32'(bus.dir_state), 32'(WAIT_PRESS));
    reset = 1'b0;
    #1;
    check("mid_rst_state", 32'(bus.dir_state), 32'(IDLE));
    check("mid_rst_outs", 32'(outs()), 32'h c);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dt_cnt = 0;
    first_d = 0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (bus.dir_tick && first_d == 0) first_d = c;
    end
    check("post_rst_lat", 32'(first_d), 32'(LAT));
    check("post_rst_count", 32'(dt_cnt), 32'd1);
    check("post_rst_cw", 32'(bus.cw), 32'd0);

    // randomized bouncy buttons vs reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 2; c++) begin
      hold[c] = 0;
      val[c] = 1'b0;
    end
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        reset = 1'b0;
        model_reset();
        #1;
        check("rand_rst_outs", 32'(outs()), 32'h c);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          val[c] = ~val[c];
          hold[c] = $urandom_range(1, 9);
        end
        hold[c]--;
      end
      bus.btn_dir = val[0];
      bus.btn_pause = val[1];
      @(posedge clk);
      model_step(val[0], val[1], e);
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("rand_queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rand%0d", n), 32'(outs()), 32'(e));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
